// File: rtl/piso_serializer.sv
// Parallel-in serial-out converter with a one-word holding register so that
// consecutive words stream out with no idle cycle between them.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last,
  output logic             busy
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             accept;
  logic             head_d;
  logic             shifting_d;

  assign accept = din_valid & din_ready;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shift_d = din;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (cnt_q == LastCnt) begin
          // Last-bit edge: the held word wins; otherwise a word arriving now bypasses the hold.
          cnt_d = '0;
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            shift_d = din;
          end else begin
            shift_d = '0;
            state_d = StIdle;
          end
        end else begin
          cnt_d   = cnt_q + CntW'(1);
          shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
          if (accept) begin
            hold_d      = din;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign shifting_d = (state_d == StShift);
  assign head_d     = MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0];

  // Outputs are registered from next-state values so they line up with the bit being shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      din_ready   <= 1'b0;
      sout        <= 1'b0;
      sout_valid  <= 1'b0;
      sout_first  <= 1'b0;
      sout_last   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      din_ready   <= ~hold_full_d;
      sout        <= shifting_d & head_d;
      sout_valid  <= shifting_d;
      sout_first  <= shifting_d && (cnt_d == '0);
      sout_last   <= shifting_d && (cnt_d == LastCnt);
    end
  end

  assign busy = (state_q == StShift) | hold_full_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus and are
// checked every cycle against a word-queue model, plus literal expectations.
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;

  logic rdy_m, sout_m, val_m, first_m, last_m, busy_m;
  logic rdy_l, sout_l, val_l, first_l, last_l, busy_l;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (rdy_m),
    .sout      (sout_m),
    .sout_valid(val_m),
    .sout_first(first_m),
    .sout_last (last_m),
    .busy      (busy_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (rdy_l),
    .sout      (sout_l),
    .sout_valid(val_l),
    .sout_first(first_l),
    .sout_last (last_l),
    .busy      (busy_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: queue of accepted words; head is on the wire, a second entry is the held word.
  logic [W-1:0] mq[$];
  int           pos = 0;
  logic         m_ready = 1'b0;
  logic         m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      pos     = 0;
      m_ready = 1'b0;
    end else begin
      m_acc = din_valid && m_ready;
      if (mq.size() > 0) begin
        pos++;
        if (pos == W) begin
          void'(mq.pop_front());
          pos = 0;
        end
      end
      if (m_acc) mq.push_back(din);
      m_ready = (mq.size() < 2);
    end
  end

  function automatic logic exp_bit(input bit msb);
    if (mq.size() == 0) return 1'b0;
    return msb ? mq[0][W-1-pos] : mq[0][pos];
  endfunction

  always @(negedge clk) begin
    logic v;
    v = (mq.size() > 0);
    chk("m_ready", rdy_m, m_ready);
    chk("m_valid", val_m, v);
    chk("m_sout", sout_m, exp_bit(1'b1));
    chk("m_first", first_m, v && pos == 0);
    chk("m_last", last_m, v && pos == W - 1);
    chk("m_busy", busy_m, v);
    chk("l_ready", rdy_l, m_ready);
    chk("l_valid", val_l, v);
    chk("l_sout", sout_l, exp_bit(1'b0));
    chk("l_first", first_l, v && pos == 0);
    chk("l_last", last_l, v && pos == W - 1);
    chk("l_busy", busy_l, v);
  end

  // Waits (bounded) for din_ready, then offers w for exactly one edge; returns just after it.
  task automatic send_word(input logic [W-1:0] w);
    int n = 0;
    @(negedge clk);
    while (!rdy_m && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", rdy_m, 1);
    din       = w;
    din_valid = 1'b1;
    @(posedge clk);
    #1 din_valid = 1'b0;
  endtask

  task automatic single(input logic [W-1:0] w, input logic [W-1:0] em, input logic [W-1:0] el);
    logic [W-1:0] sm = '0;
    logic [W-1:0] sl = '0;
    send_word(w);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      sm = {sm[W-2:0], sout_m};
      sl = {sl[W-2:0], sout_l};
      chk("single_valid", val_m, 1);
      chk("single_first", first_m, i == 0);
      chk("single_last", last_m, i == W - 1);
    end
    @(negedge clk);
    chk("single_tail_valid", val_m, 0);
    chk("single_tail_sout", sout_m, 0);
    chk("single_seq_msb", sm, em);
    chk("single_seq_lsb", sl, el);
  endtask

  // Second word offered at negedge index 'at' (cycle N+1+at), i.e. accepted at edge N+2+at.
  task automatic pair(input logic [W-1:0] w0, input logic [W-1:0] w1, input int at,
                      input logic [15:0] exp_seq, input bit expect_hold);
    logic [15:0] s = '0;
    send_word(w0);
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      s = {s[14:0], sout_m};
      chk("pair_valid", val_m, 1);
      chk("pair_busy", busy_m, 1);
      chk("pair_first", first_m, i == 0 || i == W);
      if (expect_hold) chk("pair_ready_hold", rdy_m, i <= at || i >= W);
      else chk("pair_ready_bypass", rdy_m, 1);
      if (i == at) begin
        din       = w1;
        din_valid = 1'b1;
      end else begin
        din_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("pair_tail_valid", val_m, 0);
    chk("pair_seq", s, exp_seq);
  endtask

  task automatic backpressure();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      din       = W'($urandom);
      din_valid = 1'b1;
    end
    @(negedge clk);
    din_valid = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic reset_mid();
    send_word(8'hA5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        din       = 8'h5A;
        din_valid = 1'b1;
      end else begin
        din_valid = 1'b0;
      end
    end
    chk("rst_pre_valid", val_m, 1);
    chk("rst_pre_hold", rdy_m, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_msb", {rdy_m, sout_m, val_m, first_m, last_m, busy_m}, 0);
    chk("rst_async_lsb", {rdy_l, sout_l, val_l, first_l, last_l, busy_l}, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", rdy_m, 1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("rst_no_residual_valid", val_m, 0);
      chk("rst_no_residual_sout", sout_m, 0);
    end
  endtask

  task automatic random_phase();
    int prob = 50;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (c % 100 == 0) prob = $urandom_range(10, 95);
      din_valid = ($urandom_range(0, 99) < prob);
      din       = W'($urandom);
    end
    din_valid = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ready", rdy_m, 0);
    chk("reset_outputs", {sout_m, val_m, first_m, last_m, busy_m}, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("first_edge_ready", rdy_m, 1);

    single(8'hA5, 8'hA5, 8'hA5);
    repeat (3) @(negedge clk);
    single(8'h01, 8'h01, 8'h80);
    repeat (3) @(negedge clk);
    pair(8'hFF, 8'h00, 1, 16'hFF00, 1'b1);
    repeat (3) @(negedge clk);
    pair(8'hC3, 8'h3C, W - 1, 16'hC33C, 1'b0);
    repeat (3) @(negedge clk);
    backpressure();
    reset_mid();
    random_phase();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
